ctrl_decode_stage: RTL and testbench

CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

---
 rtl/ctrl_decode_stage.sv | 138 +++++++++++++
 tb/tb_ctrl_decode_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - single-entry decode stage with memory-wait and branch-shadow squashing
module ctrl_decode_stage #(
    parameter int MEM_LAT   = 2,
    parameter int BR_SHADOW = 1,
    parameter int TAGW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      opcode,
    input  logic [TAGW-1:0] in_tag,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8:0]      control_rod,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    localparam int MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;
    localparam logic [MW-1:0] MEM_LOAD = MW'(MEM_LAT - 1);
    localparam logic [SW-1:0] SH_LOAD  = SW'(BR_SHADOW);
    localparam bit LONG_MEM  = (MEM_LAT > 1);
    localparam bit HAS_SHADW = (BR_SHADOW > 0);

    typedef enum logic [1:0] {EMPTY, FULL, MEMWAIT} state_t;

    state_t            state, state_nxt;
    logic [8:0]        ctrl_q;
    logic [TAGW-1:0]   tag_q;
    logic [MW-1:0]     mem_cnt;
    logic [SW-1:0]     shadow_cnt;

    logic pres_multi, pres_branch, transfer, accept;
    logic load_shadow, squash, take;

    function automatic logic [8:0] decode(input logic [3:0] op);
        logic [8:0] c;
        c = '0;
        if (!op[3])
            c[2:0] = op[2:0];
        else if (op == 4'b1011)
            c[4] = 1'b1;
        else if (op == 4'b1111)
            c[8] = 1'b1;
        else
            c[7:5] = op[2:0];
        return c;
    endfunction

    // The stored control word identifies the presented op: only multi-ops set bits 7:5.
    assign pres_multi  = (ctrl_q[7:5] != 3'b000);
    assign pres_branch = ctrl_q[4] | ctrl_q[8];
    assign transfer    = out_valid && out_ready;
    assign accept      = in_valid && in_ready;
    // A branch leaving this cycle already shadows an instruction accepted in the same cycle.
    assign load_shadow = HAS_SHADW && transfer && pres_branch && !flush;
    assign squash      = accept && ((shadow_cnt != '0) || load_shadow);
    assign take        = accept && !squash;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (take) state_nxt = FULL;
                FULL: begin
                    if (transfer && pres_multi && LONG_MEM)
                        state_nxt = MEMWAIT;
                    else if (take)
                        state_nxt = FULL;
                    else if (transfer)
                        state_nxt = EMPTY;
                end
                MEMWAIT: if (mem_cnt <= MW'(1)) state_nxt = EMPTY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Output logic: outputs are zeroed whenever nothing is presented
    always_comb begin
        out_valid   = (state == FULL);
        control_rod = out_valid ? ctrl_q : 9'd0;
        out_tag     = out_valid ? tag_q : '0;
        busy        = (state == MEMWAIT) || (shadow_cnt != '0);
        in_ready    = !flush && (state != MEMWAIT) &&
                      (!out_valid || (out_ready && !(pres_multi && LONG_MEM)));
    end

    // Capture decoded control and tag of each non-squashed accepted instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            tag_q  <= '0;
        end else if (take) begin
            ctrl_q <= decode(opcode);
            tag_q  <= in_tag;
        end
    end

    // Memory-wait countdown: loaded on entry to MEMWAIT, exits when it reaches one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_cnt <= '0;
        else if (flush)
            mem_cnt <= '0;
        else if (state == FULL && state_nxt == MEMWAIT)
            mem_cnt <= MEM_LOAD;
        else if (state == MEMWAIT && mem_cnt != '0)
            mem_cnt <= mem_cnt - MW'(1);
    end

    // Branch shadow: reload on taken branch, count down per squashed accept, never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow_cnt <= '0;
        else if (flush)
            shadow_cnt <= '0;
        else if (load_shadow)
            shadow_cnt <= squash ? (SH_LOAD - SW'(1)) : SH_LOAD;
        else if (squash && shadow_cnt != '0)
            shadow_cnt <= shadow_cnt - SW'(1);
    end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - scoreboard bench for ctrl_decode_stage
module tb_ctrl_decode_stage;

    localparam int MEM_LAT   = 3;
    localparam int BR_SHADOW = 1;
    localparam int TAGW      = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      opcode;
    logic [TAGW-1:0] in_tag;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [8:0]      control_rod;
    logic [TAGW-1:0] out_tag;
    logic            busy;

    ctrl_decode_stage #(.MEM_LAT(MEM_LAT), .BR_SHADOW(BR_SHADOW), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .control_rod(control_rod), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]      c;
        logic [TAGW-1:0] t;
    } item_t;

    item_t sb[$];
    int    n_chk = 0;
    int    n_bad = 0;

    // reference model state
    int         cyc_n   = 0;
    int         free_at = 0;
    int         shadow  = 0;
    bit         pres_v  = 0;
    logic [3:0] pres_op = '0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_ctrl(input logic [3:0] op);
        int v;
        v = op;
        if (v < 8)        return 9'(v);
        else if (v == 11) return 9'h010;
        else if (v == 15) return 9'h100;
        else              return 9'((v - 8) * 32);
    endfunction

    function automatic bit ref_multi(input logic [3:0] op);
        int v;
        v = op;
        return (v >= 8) && (v % 4 != 3) && (v % 8 != 0);
    endfunction

    function automatic bit ref_branch(input logic [3:0] op);
        return (op == 4'd11) || (op == 4'd15);
    endfunction

    // reference model: predicts handshake and status, pushes expected outputs
    always @(negedge clk) begin
        bit exp_rdy, acc, xfer;
        if (!rst_n) begin
            free_at = 0;
            shadow  = 0;
            pres_v  = 0;
        end else begin
            exp_rdy = !flush && (cyc_n >= free_at) &&
                      (!pres_v || (out_ready && !(ref_multi(pres_op) && MEM_LAT > 1)));
            check("in_ready", int'(in_ready), int'(exp_rdy));
            check("out_valid", int'(out_valid), int'(pres_v));
            check("busy", int'(busy), int'((cyc_n < free_at) || (shadow > 0)));
            if (flush) begin
                pres_v  = 0;
                free_at = 0;
                shadow  = 0;
            end else begin
                xfer = pres_v && out_ready;
                acc  = in_valid && exp_rdy;
                if (xfer) begin
                    if (ref_multi(pres_op) && MEM_LAT > 1) free_at = cyc_n + MEM_LAT;
                    if (ref_branch(pres_op)) shadow = BR_SHADOW;
                    pres_v = 0;
                end
                if (acc) begin
                    if (shadow > 0) begin
                        shadow = shadow - 1;
                    end else begin
                        pres_v  = 1;
                        pres_op = opcode;
                        sb.push_back('{c: ref_ctrl(opcode), t: in_tag});
                    end
                end
            end
        end
        cyc_n++;
    end

    // monitor: compares presented output with the scoreboard head
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                check("control_rod", int'(control_rod), int'(sb[0].c));
                check("out_tag", int'(out_tag), int'(sb[0].t));
                if (out_ready || flush) void'(sb.pop_front());
            end
        end else begin
            check("idle_ctrl_zero", int'(control_rod), 0);
            check("idle_tag_zero", int'(out_tag), 0);
        end
    end

    task automatic cyc(input logic v, input logic [3:0] op, input logic rdy, input logic fl);
        in_valid  = v;
        opcode    = op;
        in_tag    = TAGW'($urandom);
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset(input string name);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check({name, "_rst_out_valid"}, int'(out_valid), 0);
        check({name, "_rst_ctrl"}, int'(control_rod), 0);
        check({name, "_rst_tag"}, int'(out_tag), 0);
        check({name, "_rst_busy"}, int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_ctrl", int'(control_rod), 0);
        check("reset_tag", int'(out_tag), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        // back-to-back ALU
        cyc(1, 4'h1, 1, 0); cyc(1, 4'h2, 1, 0); cyc(1, 4'h3, 1, 0); cyc(0, 4'h0, 1, 0);
        // backpressure
        cyc(1, 4'h5, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 4'h7, 0, 0);
        cyc(0, 4'h0, 1, 0);
        // load with memory wait
        cyc(1, 4'h9, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 4'h2, 1, 0);
        cyc(0, 4'h0, 1, 0);
        // jump shadow
        cyc(1, 4'hF, 1, 0); cyc(1, 4'h1, 1, 0); cyc(1, 4'h2, 1, 0); cyc(0, 4'h0, 1, 0); cyc(0, 4'h0, 1, 0);
        // branch then shadowed load must not enter memory wait
        cyc(1, 4'hB, 1, 0); cyc(1, 4'hA, 1, 0); cyc(1, 4'h4, 1, 0); cyc(0, 4'h0, 1, 0);
        // flush during memory wait and during FULL
        cyc(1, 4'h9, 1, 0); cyc(0, 4'h0, 1, 0); cyc(1, 4'h3, 1, 1); cyc(0, 4'h0, 1, 0); cyc(0, 4'h0, 1, 0);
        cyc(1, 4'h4, 0, 0); cyc(1, 4'h6, 0, 1); cyc(0, 4'h0, 1, 0);
        // flush while a jump transfers cancels its shadow
        cyc(1, 4'hF, 1, 0); cyc(1, 4'h1, 1, 1); cyc(1, 4'h2, 1, 0); cyc(0, 4'h0, 1, 0);

        // asynchronous reset while FULL, in shadow, and in memory wait
        cyc(1, 4'h5, 0, 0);
        mid_reset("full");
        cyc(1, 4'hF, 1, 0); cyc(0, 4'h0, 1, 0);
        mid_reset("shadow");
        cyc(1, 4'h1, 1, 0); cyc(0, 4'h0, 1, 0);
        cyc(1, 4'hD, 1, 0); cyc(0, 4'h0, 1, 0);
        mid_reset("memwait");
        cyc(1, 4'h6, 1, 0); cyc(0, 4'h0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++)
            cyc(($urandom % 4) != 0, 4'($urandom), ($urandom % 10) < 7, ($urandom % 25) == 0);

        // drain
        for (int i = 0; i < 6; i++) cyc(0, 4'h0, 1, 0);
        check("drain_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
